reg_bank: RTL and testbench
===========================

// Module: reg_bank
// PURPOSE
//  Processor register bank: holds R, DR, TR, PC, AC, R1, R2, RI, RJ, RK.
//  Sits on both sides of the bus mux: its register outputs feed the bus
//  sources; it captures busout into one register selected by write_sel.
//  Also provides the in-place increment/clear/ALU-load ops the controller needs.
// PARAMETERS
//  DW    16  bus width; TR and AC are DW bits wide.
//  RW     8  width of R, DR, PC, R1, R2, RI, RJ, RK.
//  WSELW  4  width of write_sel code.
// PORTS
//  clk        in   1      clock; all state updates on rising edge.
//  rst_n      in   1      asynchronous, active-low reset.
//  stall      in   1      1: hold every register (overrides all ops).
//  write_sel  in   WSELW  bus capture target code (see BEHAVIOUR).
//  busout     in   DW     bus value to capture.
//  inc_en     in   5      increment mask {ac,rk,rj,ri,pc} = bits [4:0].
//  ac_clr     in   1      clear AC.
//  ac_ld      in   1      load AC from alu_out.
//  alu_out    in   DW     ALU result.
//  r,dr,pc    out  RW     register contents.
//  r1,r2      out  RW     register contents.
//  ri,rj,rk   out  RW     register contents.
//  tr,ac      out  DW     register contents.
//  z_flag     out  1      registered: 1 when AC == 0 after the update.
// BEHAVIOUR
//  - Reset (rst_n=0, async): every register 0; z_flag=1. Release is sync.
//  - write_sel: 0 none, 1 R, 2 DR, 3 TR, 4 PC, 5 AC, 6 R1, 7 R2, 8 RI,
//    9 RJ, 10 RK, 11-15 none (ignored, no error).
//  - RW targets take busout[RW-1:0]; TR/AC take full busout.
//  - Latency: 1 cycle; value written at edge N is visible on outputs
//    after edge N (same cycle the bus mux can reselect it).
//  - Increment: +1 modulo 2^width (PC 8'hFF -> 8'h00; AC 16'hFFFF -> 0).
//  - Per-register priority (highest first): stall > bus write > ac_ld
//    (AC only) > ac_clr (AC only) > inc_en bit > hold.
//  - Different registers update independently in the same cycle
//    (e.g. write R1 while PC increments).
//  - z_flag updated every non-stall edge from the NEXT AC value; held on stall.
//  - No internal FSM beyond the register set; each register is a small
//    load/inc/clear counter. Reset mid-operation discards any pending op.
// STRUCTURE
//  - Shared package proc_pkg: WSEL_* code constants (NONE, R, DR, TR, PC,
//    AC, R1, R2, RI, RJ, RK), INC_* bit indices, DW/RW defaults; also used
//    by the bus-mux read_en codes and the control unit.
//  - Sub-module bus_reg #(W): one register with ld/ld_val/inc/clr/stall and
//    fixed priority; instantiated 10x. Top holds the write_sel decoder,
//    AC source mux and z_flag.
// TESTING
//  1 Reset: rst_n=0 mid-cycle after loading PC=8'h33 -> all outputs 0
//    immediately, z_flag=1.
//  2 Capture: write_sel=3, busout=16'hBEEF -> tr=16'hBEEF; write_sel=1,
//    busout=16'h12AB -> r=8'hAB; write_sel=12 -> no register changes.
//  3 Wrap: pc=8'hFE, inc_en[0]=1 two cycles -> 8'hFF then 8'h00;
//    ac=16'hFFFF inc -> 0 and z_flag=1.
//  4 Conflict: write_sel=4, busout=16'h0040, inc_en[0]=1 -> pc=8'h40
//    (write wins); ac_ld=1 alu_out=16'h0005 with ac_clr=1 -> ac=5, z=0.
//  5 Parallel: write_sel=6 busout=8'h26, inc_en=5'b01110 -> r1=8'h26 and
//    ri,rj,rk each +1 same edge.
//  6 Stall: stall=1 with write_sel=5, ac_ld=1, inc_en=5'h1F -> all
//    registers and z_flag unchanged for 3 cycles; resume on stall=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor constants: bus capture codes, increment mask bits
// and default datapath widths used by the register bank and control unit.
package proc_pkg;

    localparam int DW_DEF    = 16;
    localparam int RW_DEF    = 8;
    localparam int WSELW_DEF = 4;

    // Bus capture / read-enable target codes
    localparam int WSEL_NONE = 0;
    localparam int WSEL_R    = 1;
    localparam int WSEL_DR   = 2;
    localparam int WSEL_TR   = 3;
    localparam int WSEL_PC   = 4;
    localparam int WSEL_AC   = 5;
    localparam int WSEL_R1   = 6;
    localparam int WSEL_R2   = 7;
    localparam int WSEL_RI   = 8;
    localparam int WSEL_RJ   = 9;
    localparam int WSEL_RK   = 10;

    // Bit positions in the inc_en mask
    localparam int INC_PC = 0;
    localparam int INC_RI = 1;
    localparam int INC_RJ = 2;
    localparam int INC_RK = 3;
    localparam int INC_AC = 4;
    localparam int INCW   = 5;

endpackage

// File: rtl/bus_reg.sv
// One bank register: bus load, clear and +1 with fixed priority
// stall > ld > clr > inc > hold. Exposes its next value as d.
module bus_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic [W-1:0] d
);

    always_comb begin
        d = q;
        if (stall)    d = q;
        else if (ld)  d = ld_val;
        else if (clr) d = '0;
        else if (inc) d = q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/reg_bank.sv
// Processor register bank: captures busout into the register picked by
// write_sel, and applies the controller's increment/clear/ALU-load ops.
module reg_bank
    import proc_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int RW    = RW_DEF,
    parameter int WSELW = WSELW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [WSELW-1:0] write_sel,
    input  logic [DW-1:0]    busout,
    input  logic [INCW-1:0]  inc_en,
    input  logic             ac_clr,
    input  logic             ac_ld,
    input  logic [DW-1:0]    alu_out,
    output logic [RW-1:0]    r,
    output logic [RW-1:0]    dr,
    output logic [RW-1:0]    pc,
    output logic [RW-1:0]    r1,
    output logic [RW-1:0]    r2,
    output logic [RW-1:0]    ri,
    output logic [RW-1:0]    rj,
    output logic [RW-1:0]    rk,
    output logic [DW-1:0]    tr,
    output logic [DW-1:0]    ac,
    output logic             z_flag
);

    logic wr_r, wr_dr, wr_tr, wr_pc, wr_ac;
    logic wr_r1, wr_r2, wr_ri, wr_rj, wr_rk;

    // Codes 11..15 and 0 match nothing and are silently ignored
    always_comb begin
        wr_r  = (write_sel == WSELW'(WSEL_R));
        wr_dr = (write_sel == WSELW'(WSEL_DR));
        wr_tr = (write_sel == WSELW'(WSEL_TR));
        wr_pc = (write_sel == WSELW'(WSEL_PC));
        wr_ac = (write_sel == WSELW'(WSEL_AC));
        wr_r1 = (write_sel == WSELW'(WSEL_R1));
        wr_r2 = (write_sel == WSELW'(WSEL_R2));
        wr_ri = (write_sel == WSELW'(WSEL_RI));
        wr_rj = (write_sel == WSELW'(WSEL_RJ));
        wr_rk = (write_sel == WSELW'(WSEL_RK));
    end

    logic [RW-1:0] bus_lo;
    logic [DW-1:0] ac_src;
    logic          ac_load;

    assign bus_lo  = busout[RW-1:0];
    // A bus write to AC outranks the ALU load
    assign ac_load = wr_ac | ac_ld;
    assign ac_src  = wr_ac ? busout : alu_out;

    logic [RW-1:0] r_d, dr_d, pc_d, r1_d, r2_d;
    logic [RW-1:0] ri_d, rj_d, rk_d;
    logic [DW-1:0] tr_d, ac_d;

    bus_reg #(.W(RW)) u_r (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(wr_r), .ld_val(bus_lo), .inc(1'b0), .clr(1'b0),
        .q(r), .d(r_d)
    );

    bus_reg #(.W(RW)) u_dr (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(wr_dr), .ld_val(bus_lo), .inc(1'b0), .clr(1'b0),
        .q(dr), .d(dr_d)
    );

    bus_reg #(.W(DW)) u_tr (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(wr_tr), .ld_val(busout), .inc(1'b0), .clr(1'b0),
        .q(tr), .d(tr_d)
    );

    bus_reg #(.W(RW)) u_pc (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(wr_pc), .ld_val(bus_lo), .inc(inc_en[INC_PC]), .clr(1'b0),
        .q(pc), .d(pc_d)
    );

    bus_reg #(.W(DW)) u_ac (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(ac_load), .ld_val(ac_src), .inc(inc_en[INC_AC]), .clr(ac_clr),
        .q(ac), .d(ac_d)
    );

    bus_reg #(.W(RW)) u_r1 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(wr_r1), .ld_val(bus_lo), .inc(1'b0), .clr(1'b0),
        .q(r1), .d(r1_d)
    );

    bus_reg #(.W(RW)) u_r2 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(wr_r2), .ld_val(bus_lo), .inc(1'b0), .clr(1'b0),
        .q(r2), .d(r2_d)
    );

    bus_reg #(.W(RW)) u_ri (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(wr_ri), .ld_val(bus_lo), .inc(inc_en[INC_RI]), .clr(1'b0),
        .q(ri), .d(ri_d)
    );

    bus_reg #(.W(RW)) u_rj (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(wr_rj), .ld_val(bus_lo), .inc(inc_en[INC_RJ]), .clr(1'b0),
        .q(rj), .d(rj_d)
    );

    bus_reg #(.W(RW)) u_rk (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ld(wr_rk), .ld_val(bus_lo), .inc(inc_en[INC_RK]), .clr(1'b0),
        .q(rk), .d(rk_d)
    );

    // Only AC's next value feeds z_flag; the rest are spare taps
    logic unused_d;
    assign unused_d = ^{r_d, dr_d, tr_d, pc_d, r1_d, r2_d,
                        ri_d, rj_d, rk_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      z_flag <= 1'b1;
        else if (!stall) z_flag <= (ac_d == '0);
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank.
module tb_reg_bank;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [3:0]  write_sel;
    logic [15:0] busout;
    logic [4:0]  inc_en;
    logic        ac_clr;
    logic        ac_ld;
    logic [15:0] alu_out;
    logic [7:0]  r, dr, pc, r1, r2, ri, rj, rk;
    logic [15:0] tr, ac;
    logic        z_flag;

    int checks = 0;
    int errors = 0;

    reg_bank dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .write_sel(write_sel), .busout(busout), .inc_en(inc_en),
        .ac_clr(ac_clr), .ac_ld(ac_ld), .alu_out(alu_out),
        .r(r), .dr(dr), .pc(pc), .r1(r1), .r2(r2),
        .ri(ri), .rj(rj), .rk(rk), .tr(tr), .ac(ac),
        .z_flag(z_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; write_sel = 0; busout = 0;
        inc_en = 0; ac_clr = 0; ac_ld = 0; alu_out = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [15:0] v);
        idle();
        write_sel = sel; busout = v;
        step();
        idle();
    endtask

    task automatic test_reset();
        wr(4'd4, 16'h0033);
        checks++;
        if (pc !== 8'h33) begin
            errors++;
            $display("FAIL reset_preload: pc=%h exp 33", pc);
        end
        wr(4'd3, 16'h5555);
        #3 rst_n = 0;
        #1;
        checks++;
        if ({r, dr, pc, r1, r2, ri, rj, rk} !== 64'h0 ||
            tr !== 16'h0 || ac !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h tr=%h ac=%h exp 0",
                     pc, tr, ac);
        end
        checks++;
        if (z_flag !== 1'b1) begin
            errors++;
            $display("FAIL reset_z: z=%b exp 1", z_flag);
        end
        #2 rst_n = 1;
    endtask

    task automatic test_capture();
        wr(4'd3, 16'hBEEF);
        checks++;
        if (tr !== 16'hBEEF) begin
            errors++;
            $display("FAIL cap_tr: tr=%h exp BEEF", tr);
        end
        wr(4'd1, 16'h12AB);
        checks++;
        if (r !== 8'hAB) begin
            errors++;
            $display("FAIL cap_r: r=%h exp AB", r);
        end
        wr(4'd2, 16'hAA77);
        wr(4'd7, 16'h0099);
        checks++;
        if (dr !== 8'h77 || r2 !== 8'h99) begin
            errors++;
            $display("FAIL cap_dr_r2: dr=%h r2=%h exp 77 99", dr, r2);
        end
        wr(4'd12, 16'hFFFF);
        wr(4'd15, 16'h1111);
        wr(4'd0, 16'h2222);
        checks++;
        if (tr !== 16'hBEEF || r !== 8'hAB || dr !== 8'h77 ||
            r2 !== 8'h99 || pc !== 8'h00 || ac !== 16'h0 ||
            {r1, ri, rj, rk} !== 32'h0) begin
            errors++;
            $display("FAIL cap_none: tr=%h r=%h pc=%h ac=%h changed",
                     tr, r, pc, ac);
        end
    endtask

    task automatic test_wrap();
        wr(4'd4, 16'h00FE);
        inc_en = 5'b00001;
        step();
        checks++;
        if (pc !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_pc1: pc=%h exp FF", pc);
        end
        step();
        checks++;
        if (pc !== 8'h00) begin
            errors++;
            $display("FAIL wrap_pc2: pc=%h exp 00", pc);
        end
        wr(4'd5, 16'hFFFF);
        checks++;
        if (ac !== 16'hFFFF || z_flag !== 1'b0) begin
            errors++;
            $display("FAIL wrap_acld: ac=%h z=%b exp FFFF 0", ac, z_flag);
        end
        inc_en = 5'b10000;
        step();
        idle();
        checks++;
        if (ac !== 16'h0000 || z_flag !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ac: ac=%h z=%b exp 0000 1", ac, z_flag);
        end
    endtask

    task automatic test_conflict();
        write_sel = 4'd4; busout = 16'h0040; inc_en = 5'b00001;
        step();
        idle();
        checks++;
        if (pc !== 8'h40) begin
            errors++;
            $display("FAIL conf_pc: pc=%h exp 40", pc);
        end
        ac_ld = 1; alu_out = 16'h0005; ac_clr = 1;
        step();
        idle();
        checks++;
        if (ac !== 16'h0005 || z_flag !== 1'b0) begin
            errors++;
            $display("FAIL conf_ldclr: ac=%h z=%b exp 0005 0", ac, z_flag);
        end
        ac_clr = 1; inc_en = 5'b10000;
        step();
        idle();
        checks++;
        if (ac !== 16'h0000 || z_flag !== 1'b1) begin
            errors++;
            $display("FAIL conf_clrinc: ac=%h z=%b exp 0000 1", ac, z_flag);
        end
        write_sel = 4'd5; busout = 16'h1234;
        ac_ld = 1; alu_out = 16'h0005; ac_clr = 1;
        step();
        idle();
        checks++;
        if (ac !== 16'h1234 || z_flag !== 1'b0) begin
            errors++;
            $display("FAIL conf_busac: ac=%h z=%b exp 1234 0", ac, z_flag);
        end
    endtask

    task automatic test_parallel();
        wr(4'd8, 16'h0010);
        wr(4'd9, 16'h0020);
        wr(4'd10, 16'h0030);
        write_sel = 4'd6; busout = 16'h0026; inc_en = 5'b01110;
        step();
        idle();
        checks++;
        if (r1 !== 8'h26 || ri !== 8'h11 || rj !== 8'h21 ||
            rk !== 8'h31 || pc !== 8'h40) begin
            errors++;
            $display("FAIL par: r1=%h ri=%h rj=%h rk=%h pc=%h exp 26 11 21 31 40",
                     r1, ri, rj, rk, pc);
        end
    endtask

    task automatic test_stall();
        stall = 1; write_sel = 4'd5; busout = 16'h0000;
        ac_ld = 1; alu_out = 16'h0000; inc_en = 5'h1F; ac_clr = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ac !== 16'h1234 || z_flag !== 1'b0 || pc !== 8'h40 ||
                ri !== 8'h11 || rj !== 8'h21 || rk !== 8'h31 ||
                r1 !== 8'h26 || tr !== 16'hBEEF) begin
                errors++;
                $display("FAIL stall_%0d: ac=%h z=%b pc=%h ri=%h exp 1234 0 40 11",
                         i, ac, z_flag, pc, ri);
            end
        end
        stall = 0;
        step();
        idle();
        checks++;
        if (ac !== 16'h0000 || z_flag !== 1'b1 || pc !== 8'h41 ||
            ri !== 8'h12 || rj !== 8'h22 || rk !== 8'h32) begin
            errors++;
            $display("FAIL resume: ac=%h z=%b pc=%h ri=%h rj=%h rk=%h",
                     ac, z_flag, pc, ri, rj, rk);
        end
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        checks++;
        if (pc !== 8'h00 || ac !== 16'h0 || z_flag !== 1'b1) begin
            errors++;
            $display("FAIL init: pc=%h ac=%h z=%b", pc, ac, z_flag);
        end
        test_reset();
        test_capture();
        test_wrap();
        test_conflict();
        test_parallel();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
